// File: rtl/mux_4x1_pkg.sv
// Shared lane types and constants for the registered 4:1 lane multiplexer.
package mux_4x1_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  localparam lane_sel_t LANE0 = 2'd0;
  localparam lane_sel_t LANE1 = 2'd1;
  localparam lane_sel_t LANE2 = 2'd2;
  localparam lane_sel_t LANE3 = 2'd3;

  function automatic logic lane_enabled(input logic [NUM_LANES-1:0] mask,
                                        input lane_sel_t sel);
    return mask[sel];
  endfunction

endpackage

// File: rtl/mux_4x1_comb.sv
// Purely combinational N-bit 4:1 lane selector.
module mux_4x1_comb
  import mux_4x1_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  input  lane_sel_t    sel,
  output logic [N-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      LANE0: out = in0;
      LANE1: out = in1;
      LANE2: out = in2;
      LANE3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/mux_4x1.sv
// Registered 4:1 lane multiplexer with valid qualifier, per-lane enable mask and lane echo.
// Optional even-parity output out_par is enabled by defining MUX_4X1_PARITY_EN.
module mux_4x1
  import mux_4x1_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in0,
  input  logic [N-1:0]         in1,
  input  logic [N-1:0]         in2,
  input  logic [N-1:0]         in3,
  input  lane_sel_t            sel,
  input  logic                 in_valid,
  input  logic [NUM_LANES-1:0] en_mask,
  output logic [N-1:0]         out,
  output logic                 out_valid,
  output lane_sel_t            out_sel,
  output logic                 sel_err
`ifdef MUX_4X1_PARITY_EN
  ,
  output logic                 out_par
`endif
);

`ifdef MUX_4X1_PARITY_EN
  function automatic logic even_par(input logic [N-1:0] d);
    return ^d;
  endfunction
`endif

  // Stage p0: lane select and mask check
  logic [N-1:0] mux_p0;
  logic         en_p0;
  logic [N-1:0] data_p0;

  mux_4x1_comb #(.N(N)) u_comb (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (sel),
    .out (mux_p0)
  );

  assign en_p0   = lane_enabled(en_mask, sel);
  assign data_p0 = en_p0 ? mux_p0 : '0;

  // Stage p1: output registers; data/lane hold when nothing is accepted
  logic [N-1:0] out_p1;
  lane_sel_t    sel_p1;
  logic         vld_p1;
  logic         err_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_p1 <= '0;
      sel_p1 <= LANE0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (in_valid) begin
      out_p1 <= data_p0;
      sel_p1 <= sel;
      vld_p1 <= 1'b1;
      err_p1 <= ~en_p0;
    end else begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end
  end

`ifdef MUX_4X1_PARITY_EN
  logic par_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_p1 <= 1'b0;
    end else if (in_valid) begin
      par_p1 <= even_par(data_p0);
    end
  end

  assign out_par = par_p1;
`endif

  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign out_sel   = sel_p1;
  assign sel_err   = err_p1;

endmodule

// File: tb/tb_mux_4x1.sv
// Scoreboard bench for mux_4x1: expectations queued at drive time, compared one cycle later.
module tb_mux_4x1;

  localparam int N = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in0, in1, in2, in3;
  logic [1:0]   sel;
  logic         in_valid;
  logic [3:0]   en_mask;
  logic [N-1:0] out;
  logic         out_valid;
  logic [1:0]   out_sel;
  logic         sel_err;
`ifdef MUX_4X1_PARITY_EN
  logic         out_par;
`endif

  mux_4x1 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .sel       (sel),
    .in_valid  (in_valid),
    .en_mask   (en_mask),
    .out       (out),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .sel_err   (sel_err)
`ifdef MUX_4X1_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [N-1:0] o;
    logic         v;
    logic [1:0]   s;
    logic         e;
    logic         p;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [N-1:0] m_out = '0;
  logic [1:0]   m_sel = 2'b00;
  logic         m_par = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input string tag, input logic r, input logic v, input logic [1:0] s,
                       input logic [3:0] m, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input logic [N-1:0] d);
    exp_t         e;
    logic [N-1:0] lane;
    @(negedge clk);
    rst_n = r; in_valid = v; sel = s; en_mask = m;
    in0 = a; in1 = b; in2 = c; in3 = d;
    e.tag = tag;
    if (!r) begin
      m_out = '0; m_sel = 2'b00; m_par = 1'b0;
      e.v = 1'b0; e.e = 1'b0;
    end else if (v) begin
      case (s)
        2'd0: lane = a;
        2'd1: lane = b;
        2'd2: lane = c;
        default: lane = d;
      endcase
      m_out = m[s] ? lane : '0;
      m_sel = s;
      m_par = ^m_out;
      e.v = 1'b1; e.e = ~m[s];
    end else begin
      e.v = 1'b0; e.e = 1'b0;
    end
    e.o = m_out; e.s = m_sel; e.p = m_par;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      #1;
      check({e.tag, ".out"},       32'(out),       32'(e.o));
      check({e.tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
      check({e.tag, ".out_sel"},   32'(out_sel),   32'(e.s));
      check({e.tag, ".sel_err"},   32'(sel_err),   32'(e.e));
`ifdef MUX_4X1_PARITY_EN
      check({e.tag, ".out_par"},   32'(out_par),   32'(e.p));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 2'b00; en_mask = 4'hF;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;

    drive("reset0", 1'b0, 1'b1, 2'b11, 4'hF, 3'd5, 3'd6, 3'd7, 3'd7);
    drive("reset1", 1'b0, 1'b1, 2'b10, 4'hF, 3'd5, 3'd6, 3'd7, 3'd7);

    for (int i = 0; i < 4; i++)
      drive("sweep", 1'b1, 1'b1, 2'(i), 4'b1111, 3'b000, 3'b001, 3'b010, 3'b011);

    drive("mask_hit", 1'b1, 1'b1, 2'b10, 4'b1011, 3'b000, 3'b001, 3'b010, 3'b011);
    drive("mask_ok",  1'b1, 1'b1, 2'b11, 4'b1011, 3'b000, 3'b001, 3'b010, 3'b011);

    drive("hold_ld",  1'b1, 1'b1, 2'b01, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b011);
    drive("hold0",    1'b1, 1'b0, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b111);
    drive("hold_x",   1'b1, 1'b0, 2'bxx, 4'b0000, 3'b110, 3'b101, 3'b100, 3'b111);

    drive("stream0",  1'b1, 1'b1, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b101);
    drive("stream1",  1'b1, 1'b1, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b110);
    drive("midrst",   1'b0, 1'b1, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b110);
    drive("resume",   1'b1, 1'b1, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b110);

    drive("par_even", 1'b1, 1'b1, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b011);
    drive("par_odd",  1'b1, 1'b1, 2'b11, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b111);
    drive("par_mask", 1'b1, 1'b1, 2'b11, 4'b0111, 3'b000, 3'b001, 3'b010, 3'b111);
    drive("par_hold", 1'b1, 1'b0, 2'b00, 4'b1111, 3'b000, 3'b001, 3'b010, 3'b111);

    for (int i = 0; i < 40; i++)
      drive("rand", 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom));

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("q_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
